// File: rtl/permute_pipe_param.sv
// Quadword shift/rotate/gather permute unit with a STAGES-deep lock-step pipeline.
// Gather ops (GBB/GBH/GB) are built only when PERMUTE_GATHER_EN is defined.
`timescale 1ns/1ps
module permute_pipe_param #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned STAGES = 2,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] ra,
   input  logic [DATA_W-1:0] rb,
   input  logic [6:0]        i7,
   input  logic [ADDR_W-1:0] rt_addr_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rt,
   output logic [ADDR_W-1:0] out_rt_addr,
   output logic [2:0]        occupancy
);

   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(NBYTES) + 1;
   localparam int unsigned SH_W   = $clog2(DATA_W);

   typedef enum logic [3:0] {
      OP_SHLQBI   = 4'd0,
      OP_SHLQBII  = 4'd1,
      OP_SHLQBY   = 4'd2,
      OP_SHLQBYI  = 4'd3,
      OP_SHLQBYBI = 4'd4,
      OP_ROTQBY   = 4'd5,
      OP_ROTQBYI  = 4'd6,
      OP_ROTQBYBI = 4'd7,
      OP_ROTQBI   = 4'd8,
      OP_ROTQBII  = 4'd9,
      OP_ROTQMBY  = 4'd10,
      OP_ROTQMBYI = 4'd11,
      OP_GBB      = 4'd12,
      OP_GBH      = 4'd13,
      OP_GB       = 4'd14,
      OP_ZERO     = 4'd15
   } op_e;

   op_e               op_sel;
   logic              imm_form;
   logic [2:0]        bit_cnt;
   logic [CNT_W-1:0]  byte_cnt;
   logic [CNT_W-1:0]  mask_cnt;
   logic [SH_W-1:0]   byte_sh;
   logic [SH_W-1:0]   mask_sh;
   logic [DATA_W-1:0] result;
   logic              advance;
   logic              accept;
   logic              deliver;
   logic [2:0]        occ_q;
   logic [2:0]        occ_nxt;
   logic              unused_bits;

   logic              stage_vld  [STAGES];
   logic [DATA_W-1:0] stage_rt   [STAGES];
   logic [ADDR_W-1:0] stage_addr [STAGES];

   // Bits of rb/i7 beyond the count fields never influence the result.
   assign unused_bits = ^{rb[DATA_W-1:CNT_W+3], i7[6:CNT_W]};

   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                              input logic [SH_W-1:0]   n);
      logic [2*DATA_W-1:0] d;
      d = {v, v} << n;
      return d[2*DATA_W-1 -: DATA_W];
   endfunction

   // Count extraction: bit counts are the last 3 bits, byte counts the low CNT_W bits.
   always_comb begin
      op_sel   = op_e'(op);
      imm_form = op_sel inside {OP_SHLQBII, OP_SHLQBYI, OP_ROTQBYI, OP_ROTQBII, OP_ROTQMBYI};
      bit_cnt  = imm_form ? i7[2:0] : rb[2:0];
      if (op_sel == OP_SHLQBYBI || op_sel == OP_ROTQBYBI) begin
         byte_cnt = rb[CNT_W+2:3];
      end else begin
         byte_cnt = imm_form ? i7[CNT_W-1:0] : rb[CNT_W-1:0];
      end
      mask_cnt = ~byte_cnt + CNT_W'(1);
      byte_sh  = {byte_cnt[CNT_W-2:0], 3'b000};
      mask_sh  = {mask_cnt[CNT_W-2:0], 3'b000};
   end

`ifdef PERMUTE_GATHER_EN
   logic [31:0] gather;

   always_comb begin
      gather = '0;
      case (op_sel)
         OP_GBB: for (int unsigned i = 0; i < NBYTES; i++) gather[i] = ra[8*i];
         OP_GBH: for (int unsigned i = 0; i < DATA_W/16; i++) gather[i] = ra[16*i];
         OP_GB:  for (int unsigned i = 0; i < DATA_W/32; i++) gather[i] = ra[32*i];
         default: gather = '0;
      endcase
   end
`endif

   // Result select; a count with its top bit set is out of range for shifts.
   always_comb begin
      result = '0;
      case (op_sel)
         OP_SHLQBI, OP_SHLQBII:
            result = ra << bit_cnt;
         OP_SHLQBY, OP_SHLQBYI, OP_SHLQBYBI:
            result = byte_cnt[CNT_W-1] ? '0 : ra << byte_sh;
         OP_ROTQBY, OP_ROTQBYI, OP_ROTQBYBI:
            result = rotl(ra, byte_sh);
         OP_ROTQBI, OP_ROTQBII:
            result = rotl(ra, SH_W'(bit_cnt));
         OP_ROTQMBY, OP_ROTQMBYI:
            result = mask_cnt[CNT_W-1] ? '0 : ra >> mask_sh;
`ifdef PERMUTE_GATHER_EN
         OP_GBB, OP_GBH, OP_GB:
            result[DATA_W-1 -: 32] = gather;
`endif
         default:
            result = '0;
      endcase
   end

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !flush;
   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid && out_ready;

   // Lock-step pipeline: every stage moves only when the output slot can drain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_vld[i]  <= 1'b0;
            stage_rt[i]   <= '0;
            stage_addr[i] <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < STAGES; i++) stage_vld[i] <= 1'b0;
      end else if (advance) begin
         stage_vld[0]  <= in_valid;
         stage_rt[0]   <= result;
         stage_addr[0] <= rt_addr_in;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stage_vld[i]  <= stage_vld[i-1];
            stage_rt[i]   <= stage_rt[i-1];
            stage_addr[i] <= stage_addr[i-1];
         end
      end
   end

   always_comb begin
      occ_nxt = occ_q;
      if (flush) begin
         occ_nxt = 3'd0;
      end else if (accept && !deliver && occ_q < 3'(STAGES)) begin
         occ_nxt = occ_q + 3'd1;
      end else if (!accept && deliver && occ_q != 3'd0) begin
         occ_nxt = occ_q - 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) occ_q <= 3'd0;
      else        occ_q <= occ_nxt;
   end

   assign out_valid   = stage_vld[STAGES-1];
   assign out_rt      = stage_rt[STAGES-1];
   assign out_rt_addr = stage_addr[STAGES-1];
   assign occupancy   = occ_q;

endmodule

// File: tb/tb_permute_pipe_param.sv
// Self-checking bench for permute_pipe_param: byte/bit-array reference model plus
// a per-cycle scoreboard that tracks how far each accepted request has advanced.
`timescale 1ns/1ps
module tb_permute_pipe_param;

   localparam int DW = 128;
   localparam int ST = 2;
   localparam int AW = 7;

   logic          clock;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    op;
   logic [DW-1:0] ra;
   logic [DW-1:0] rb;
   logic [6:0]    i7;
   logic [AW-1:0] rt_addr_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_rt;
   logic [AW-1:0] out_rt_addr;
   logic [2:0]    occupancy;

   permute_pipe_param #(.DATA_W(DW), .STAGES(ST), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .ra(ra), .rb(rb), .i7(i7), .rt_addr_in(rt_addr_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rt(out_rt), .out_rt_addr(out_rt_addr), .occupancy(occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [DW-1:0] rt;
      logic [AW-1:0] addr;
      int            adv;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   delivered = 0;
   int   peak = 0;
   logic m_vld;
   logic m_adv;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Big-endian bit view: position 0 is the MSB; out-of-range positions read as zero.
   function automatic logic be_bit(input logic [DW-1:0] v, input int p);
      if (p < 0 || p >= DW) return 1'b0;
      return v[DW-1-p];
   endfunction

   function automatic logic [DW-1:0] model(input logic [3:0] o, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [6:0] imm);
      int nb, m, bits, cnt, s, es, n;
      logic imm_f;
      logic [DW-1:0] r;
      nb = DW / 8;
      m  = 2 * nb;
      r  = '0;
      imm_f = (o == 4'd1 || o == 4'd3 || o == 4'd6 || o == 4'd9 || o == 4'd11);
      bits  = imm_f ? int'(imm) % 8 : int'(b[7:0]) % 8;
      if (o == 4'd4 || o == 4'd7) cnt = int'(b[10:3]) % m;
      else                        cnt = imm_f ? int'(imm) % m : int'(b[7:0]) % m;
      case (o)
         4'd0, 4'd1: for (int p = 0; p < DW; p++) r[DW-1-p] = be_bit(a, p + bits);
         4'd8, 4'd9: for (int p = 0; p < DW; p++) r[DW-1-p] = be_bit(a, (p + bits) % DW);
         4'd2, 4'd3, 4'd4:
            if (cnt < nb) for (int p = 0; p < DW; p++) r[DW-1-p] = be_bit(a, p + 8*cnt);
         4'd5, 4'd6, 4'd7:
            for (int p = 0; p < DW; p++) r[DW-1-p] = be_bit(a, (p + 8*(cnt % nb)) % DW);
         4'd10, 4'd11: begin
            s = (m - cnt) % m;
            if (s < nb) for (int p = 0; p < DW; p++) r[DW-1-p] = be_bit(a, p - 8*s);
         end
`ifdef PERMUTE_GATHER_EN
         4'd12, 4'd13, 4'd14: begin
            es = (o == 4'd12) ? 8 : (o == 4'd13) ? 16 : 32;
            n  = DW / es;
            for (int e = 0; e < n; e++) r[DW-1-(32-n+e)] = be_bit(a, (e+1)*es - 1);
         end
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // Per-cycle compare, then step the scoreboard for the coming edge.
   always @(negedge clock) begin
      if (!reset) begin
         chk("rst_out_valid", DW'(out_valid), '0);
         chk("rst_out_rt", out_rt, '0);
         chk("rst_out_rt_addr", DW'(out_rt_addr), '0);
         chk("rst_occupancy", DW'(occupancy), '0);
         q.delete();
      end else begin
         m_vld = (q.size() > 0) && (q[0].adv >= ST);
         chk("out_valid", DW'(out_valid), DW'(m_vld));
         chk("occupancy", DW'(occupancy), DW'(q.size()));
         chk("in_ready", DW'(in_ready), DW'((!m_vld || out_ready) && !flush));
         if (m_vld) begin
            chk("out_rt", out_rt, q[0].rt);
            chk("out_rt_addr", DW'(out_rt_addr), DW'(q[0].addr));
         end
         if (int'(occupancy) > peak) peak = int'(occupancy);
         if (flush) begin
            q.delete();
         end else begin
            m_adv = !m_vld || out_ready;
            if (m_vld && out_ready) begin
               void'(q.pop_front());
               delivered++;
            end
            if (m_adv) begin
               for (int i = 0; i < q.size(); i++) q[i].adv = q[i].adv + 1;
               if (in_valid) q.push_back('{rt: model(op, ra, rb, i7), addr: rt_addr_in, adv: 1});
            end
         end
      end
   end

   // Present a request at posedge+1 and hold it until accepted (bounded).
   task automatic issue(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [6:0] imm, input logic [AW-1:0] adr);
      logic got;
      got = 1'b0;
      op = o; ra = a; rb = b; i7 = imm; rt_addr_in = adr; in_valid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clock);
         got = in_ready;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout: got in_ready 0 for 20 cycles expected 1");
      end
   endtask

   task automatic lit(input string name, input logic [3:0] o, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [6:0] imm, input logic [DW-1:0] exp);
      issue(o, a, b, imm, AW'(o));
      repeat (ST-1) @(posedge clock);
      #1;
      chk({name, "_valid"}, DW'(out_valid), DW'(1));
      chk(name, out_rt, exp);
      @(posedge clock);
      #1;
   endtask

   localparam logic [DW-1:0] P = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [DW-1:0] Q = 128'h80000000_00000000_00000000_00000001;
`ifdef PERMUTE_GATHER_EN
   localparam logic [DW-1:0] GBB_EXP = 128'd1 << 96;
`else
   localparam logic [DW-1:0] GBB_EXP = '0;
`endif

   logic [DW-1:0] held;
   int            dlv0;

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; ra = '0; rb = '0;
      i7 = '0; rt_addr_in = '0; out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_out_valid", DW'(out_valid), '0);
      chk("reset_occupancy", DW'(occupancy), '0);
      reset = 1'b1;

      // Hand-computed values pinning the reference model.
      chk("pin_shlqbi", model(4'd0, 128'd20, 128'd10, 7'd0), 128'd80);
      chk("pin_shlqbii", model(4'd1, 128'd15, '0, 7'd5), 128'd480);
      chk("pin_shlqby", model(4'd2, 128'd25, 128'd110, 7'd0), 128'd25 << 112);
      chk("pin_rotqby", model(4'd5, 128'd77, 128'd34, 7'd0), 128'd77 << 16);
      chk("pin_rotqbyi", model(4'd6, 128'd1 << 120, '0, 7'd1), 128'd1);
      chk("pin_rotqmby", model(4'd10, 128'hAB00, 128'd31, 7'd0), 128'hAB);
      chk("pin_shlqby_oob", model(4'd2, P, 128'd16, 7'd0), '0);
      chk("pin_gbb", model(4'd12, 128'd15, '0, 7'd0), GBB_EXP);

      // Literal checks through the DUT.
      lit("dut_shlqbi", 4'd0, 128'd20, 128'd10, 7'd0, 128'd80);
      lit("dut_shlqbii", 4'd1, 128'd15, '0, 7'd5, 128'd480);
      lit("dut_shlqby", 4'd2, 128'd25, 128'd110, 7'd0, 128'd25 << 112);
      lit("dut_rotqby", 4'd5, 128'd77, 128'd34, 7'd0, 128'd77 << 16);
      lit("dut_rotqbyi", 4'd6, 128'd1 << 120, '0, 7'd1, 128'd1);
      lit("dut_gbb", 4'd12, 128'd15, '0, 7'd0, GBB_EXP);

      // Directed vectors back to back, scoreboard-checked.
      issue(4'd0, P, 128'd7, 7'd0, 7'd1);
      issue(4'd0, P, ~128'd5, 7'd0, 7'd2);
      issue(4'd1, P, '0, 7'h7F, 7'd3);
      issue(4'd2, P, 128'd16, 7'd0, 7'd4);
      issue(4'd2, P, 128'd15, 7'd0, 7'd5);
      issue(4'd3, P, '0, 7'h1F, 7'd6);
      issue(4'd4, P, 128'd24, 7'd0, 7'd7);
      issue(4'd4, P, 128'h80, 7'd0, 7'd8);
      issue(4'd5, P, 128'd17, 7'd0, 7'd9);
      issue(4'd6, P, '0, 7'h4F, 7'd10);
      issue(4'd7, P, 128'd40, 7'd0, 7'd11);
      issue(4'd8, Q, 128'd5, 7'd0, 7'd12);
      issue(4'd9, Q, '0, 7'd3, 7'd13);
      issue(4'd10, P, '0, 7'd0, 7'd14);
      issue(4'd10, P, 128'd16, 7'd0, 7'd15);
      issue(4'd10, P, 128'd20, 7'd0, 7'd16);
      issue(4'd11, P, '0, 7'd30, 7'd17);
      issue(4'd12, P, '0, 7'd0, 7'd18);
      issue(4'd13, P, '0, 7'd0, 7'd19);
      issue(4'd14, P, '0, 7'd0, 7'd20);
      issue(4'd15, P, P, 7'h7F, 7'd21);
      repeat (ST + 2) @(posedge clock);
      #1;

      // Back-to-back stream with a 3-cycle output stall.
      peak = 0;
      dlv0 = delivered;
      fork
         begin
            issue(4'd0, 128'd20, 128'd10, 7'd0, 7'd30);
            issue(4'd5, P, 128'd3, 7'd0, 7'd31);
            issue(4'd10, P, 128'd30, 7'd0, 7'd32);
            issue(4'd2, P, 128'd1, 7'd0, 7'd33);
         end
         begin
            repeat (2) @(posedge clock);
            #1;
            out_ready = 1'b0;
            held = out_rt;
            chk("stall_head", out_rt, 128'd80);
            repeat (3) @(posedge clock);
            #1;
            chk("stall_hold", out_rt, held);
            chk("stall_in_ready", DW'(in_ready), '0);
            out_ready = 1'b1;
         end
      join
      repeat (ST + 3) @(posedge clock);
      #1;
      chk("stall_delivered", DW'(delivered - dlv0), DW'(4));
      chk("stall_peak", DW'(peak), DW'(ST));

      // Flush with two in flight; the request presented alongside is dropped.
      issue(4'd0, P, 128'd1, 7'd0, 7'd40);
      issue(4'd5, P, 128'd1, 7'd0, 7'd41);
      out_ready = 1'b0; flush = 1'b1;
      op = 4'd0; ra = P; rb = 128'd2; rt_addr_in = 7'd42; in_valid = 1'b1;
      #1;
      chk("flush_in_ready", DW'(in_ready), '0);
      chk("flush_occ_before", DW'(occupancy), DW'(2));
      @(posedge clock);
      #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("flush_out_valid", DW'(out_valid), '0);
      chk("flush_occupancy", DW'(occupancy), '0);
      repeat (ST + 2) @(posedge clock);
      #1;

      // Asynchronous reset in the middle of a stream.
      issue(4'd8, Q, 128'd1, 7'd0, 7'd50);
      issue(4'd9, Q, '0, 7'd2, 7'd51);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", DW'(out_valid), '0);
      chk("arst_out_rt", out_rt, '0);
      chk("arst_out_rt_addr", DW'(out_rt_addr), '0);
      chk("arst_occupancy", DW'(occupancy), '0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      lit("post_rst_rotqbyi", 4'd6, 128'd1 << 120, '0, 7'd1, 128'd1);
      repeat (ST + 3) @(posedge clock);
      #1;
      chk("sb_empty", DW'(q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/permute_pipe_param.md
PERMUTE_PIPE_PARAM -- requirements
Module: permute_pipe_param

Interface
REQ-001 SHALL have parameter DATA_W, default 128, quadword width in bits; legal values 64, 128, 256.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth (1..4).
REQ-003 SHALL have parameter ADDR_W, default 7, register-target address width.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous pipeline squash.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-009 SHALL have port op  input  4  operation select (REQ-016).
REQ-010 SHALL have ports ra, rb  input  DATA_W  operands, bit 0 = MSB.
REQ-011 SHALL have port i7  input  7  immediate count.
REQ-012 SHALL have port rt_addr_in  input  ADDR_W  destination register.
REQ-013 SHALL have ports out_valid  output  1, out_ready  input  1  result handshake.
REQ-014 SHALL have ports out_rt  output  DATA_W, out_rt_addr  output  ADDR_W  result and destination.
REQ-015 SHALL have port occupancy  output  3  count of valid entries in flight.

Function
REQ-016 SHALL decode op: 0 SHLQBI, 1 SHLQBII, 2 SHLQBY, 3 SHLQBYI, 4 SHLQBYBI, 5 ROTQBY, 6 ROTQBYI, 7 ROTQBYBI, 8 ROTQBI, 9 ROTQBII, 10 ROTQMBY, 11 ROTQMBYI, 12 GBB, 13 GBH, 14 GB; op 15 yields out_rt = 0.
REQ-017 SHALL take bit counts from rb[DATA_W-3:DATA_W-1] (register forms) or i7[4:6] (immediate forms), range 0..7.
REQ-018 SHALL take byte counts from the low log2(DATA_W/8)+1 bits of rb (or i7); SHLQBYBI/ROTQBYBI use rb bits shifted right by 3 first.
REQ-019 SHALL zero the result for shift-by-bytes with count >= DATA_W/8; rotates use count modulo DATA_W/8.
REQ-020 SHALL implement ROTQMBY/ROTQMBYI as logical right shift by (-count) mod 2*(DATA_W/8) bytes, zero-filling, zero if >= DATA_W/8.
REQ-021 SHALL implement GBB/GBH/GB by collecting the LSB of each byte/halfword/word of ra, right-justified in word 0 of out_rt, all other bits 0.
REQ-022 SHALL have latency exactly STAGES cycles from acceptance to out_valid when out_ready stays high.
REQ-023 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready = advance.
REQ-024 SHALL hold out_rt, out_rt_addr, out_valid stable while out_valid && !out_ready.
REQ-025 SHALL sustain one accepted request per cycle with continuous out_ready.
REQ-026 SHALL, on flush, clear every stage valid bit and occupancy at the next edge; a request presented with flush is dropped, in_ready forced 0 that cycle.
REQ-027 SHALL keep occupancy = accepted minus delivered minus flushed, saturating at STAGES; simultaneous accept and deliver leave it unchanged.

Reset
REQ-028 SHALL, while reset is low, force out_valid 0, out_rt 0, out_rt_addr 0, occupancy 0, all stage valids 0, asynchronously.
REQ-029 SHALL drop in-flight requests when reset asserts mid-operation; first acceptance occurs on the first edge after release.

Configuration
REQ-030 SHALL compile gather logic only when macro PERMUTE_GATHER_EN is defined; otherwise ops 12-14 behave as op 15 (result 0, valid timing unchanged).

Verification
REQ-031 SHLQBI ra=20, rb=10 -> out_rt=80 after STAGES cycles.
REQ-032 SHLQBII ra=15, i7=5 -> 480; SHLQBY ra=25, rb=110 (count 14) -> 25<<112 (DATA_W=128).
REQ-033 ROTQBY ra=77, rb=34 (count 2) -> 77<<16; ROTQBYI ra=1<<120, i7=1 -> 1 (byte wrap).
REQ-034 GBB ra=15 -> out_rt=1<<96 with PERMUTE_GATHER_EN, 0 without.
REQ-035 Back-to-back 4 requests, out_ready low 3 cycles mid-stream -> outputs held, in_ready 0, order preserved, none lost; occupancy peaks at STAGES.
REQ-036 flush with 2 in flight -> out_valid 0 and occupancy 0 next cycle; reset asserted mid-stream -> all outputs 0 immediately.
